id_ex_pipeline_register: RTL

Pipeline register between instruction decode and the execute stage. It feeds `arithmetic_logic_unit` its `op`, `rs`, `rt` and `en` inputs. It resolves operand bypassing from the EX/MEM and MEM/WB stages and detects load-use hazards. It also keeps held operands fresh while the pipeline is stalled.

---
 rtl/id_ex_pipeline_register_pkg.sv | 28 ++
 rtl/id_ex_pipeline_register_operand_forward_mux.sv | 47 ++++
 rtl/id_ex_pipeline_register.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipeline_register_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_register_pkg
// Shared widths and constants for the ID/EX pipeline register and its
// operand bypass mux.
//   DATA_BUS      operand width fed to the ALU
//   ALU_OP_WIDTH  width of the decoded ALU opcode
//   ALU_OP_NOP    opcode loaded into EX for a bubble
//   REG_ADDR_BUS  register-file address width
//   REG_ZERO      hard-wired zero register, never bypassed
//   fwd_sel_e     operand source chosen by the bypass mux
// ---------------------------------------------------------------------------
package id_ex_pipeline_register_pkg;

    localparam int DATA_BUS     = 32;
    localparam int ALU_OP_WIDTH = 4;
    localparam int REG_ADDR_BUS = 5;

    // Non-zero so a bubble is distinguishable from a cleared opcode field.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = 4'hF;
    localparam logic [REG_ADDR_BUS-1:0] REG_ZERO   = '0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_pipeline_register_operand_forward_mux.sv
// ---------------------------------------------------------------------------
// operand_forward_mux
// Combinational bypass select for one source operand. EX/MEM wins over
// MEM/WB; register zero is never bypassed.
// Ports:
//   i_src_addr                     source register address
//   i_dflt_data                    data used when no bypass source matches
//   i_exmem_wb_en/_rd_addr/_result EX/MEM bypass source
//   i_memwb_wb_en/_rd_addr/_result MEM/WB bypass source
//   o_data                         selected operand
// ---------------------------------------------------------------------------
module operand_forward_mux
    import id_ex_pipeline_register_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS,
    parameter int ADDR_WIDTH = REG_ADDR_BUS
) (
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [DATA_WIDTH-1:0] i_dflt_data,
    input  logic                  i_exmem_wb_en,
    input  logic [ADDR_WIDTH-1:0] i_exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_exmem_result,
    input  logic                  i_memwb_wb_en,
    input  logic [ADDR_WIDTH-1:0] i_memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_memwb_result,
    output logic [DATA_WIDTH-1:0] o_data
);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (i_exmem_wb_en && (i_exmem_rd_addr != '0) && (i_exmem_rd_addr == i_src_addr))
            w_sel = FWD_EXMEM;
        else if (i_memwb_wb_en && (i_memwb_rd_addr != '0) && (i_memwb_rd_addr == i_src_addr))
            w_sel = FWD_MEMWB;
    end

    always_comb begin
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_dflt_data;
        endcase
    end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_register
// ID/EX pipeline register feeding the ALU. Resolves operand bypassing from
// EX/MEM and MEM/WB, detects hazards and refreshes held operands while the
// pipeline is stalled.
// Build option: define ID_EX_FORWARDING_EN to enable bypass + stall refresh
// with load-use hazard detection. Without it, operands come straight from the
// register file / immediate and any source match against an in-flight writer
// (EX, EX/MEM, MEM/WB) raises hazard_stall.
// Ports:
//   clk, rst_n (sync, active-low), stall, flush
//   id_*      decode slot (valid, op, addresses, data, imm, control)
//   exmem_*   EX/MEM bypass source,  memwb_* MEM/WB bypass source
//   ex_*      registered EX slot; ex_alu_en == ex_valid
//   hazard_stall  combinational; controller holds IF/ID while high
// ---------------------------------------------------------------------------
module id_ex_pipeline_register
    import id_ex_pipeline_register_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_BUS,
    parameter int REG_ADDR_WIDTH = REG_ADDR_BUS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_use_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_wb_en,
    input  logic                      id_mem_read,
    input  logic                      exmem_wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      ex_valid,
    output logic                      ex_alu_en,
    output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
    output logic [DATA_WIDTH-1:0]     ex_rs,
    output logic [DATA_WIDTH-1:0]     ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs_addr,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt_addr,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_wb_en,
    output logic                      ex_mem_read,
    output logic                      ex_use_imm,
    output logic                      hazard_stall
);

    typedef struct packed {
        logic                      valid;
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic [REG_ADDR_WIDTH-1:0] rs_addr;
        logic [REG_ADDR_WIDTH-1:0] rt_addr;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      wb_en;
        logic                      mem_read;
        logic                      use_imm;
        logic [DATA_WIDTH-1:0]     rs;
        logic [DATA_WIDTH-1:0]     rt;
    } ex_slot_t;

    function automatic logic f_hit(input logic                      en,
                                   input logic [REG_ADDR_WIDTH-1:0] rd,
                                   input logic [REG_ADDR_WIDTH-1:0] src);
        return en && (rd != '0) && (rd == src);
    endfunction

    ex_slot_t r_ex;
    ex_slot_t w_bubble;
    ex_slot_t w_load;
    ex_slot_t w_hold;

    logic [DATA_WIDTH-1:0] w_ld_rs, w_ld_rt, w_rf_rs, w_rf_rt;
    logic                  w_exmem_fwd, w_memwb_fwd;

`ifdef ID_EX_FORWARDING_EN
    assign w_exmem_fwd = exmem_wb_en;
    assign w_memwb_fwd = memwb_wb_en;

    // Only a load in EX can't be bypassed in time; everything else forwards.
    assign hazard_stall = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd_addr != '0) &
                          ((r_ex.rd_addr == id_rs_addr) |
                           (!id_use_imm & (r_ex.rd_addr == id_rt_addr)));
`else
    // Bypass sources masked off: the muxes degenerate to register-file data
    // and the hold path keeps the stored operands.
    assign w_exmem_fwd = 1'b0;
    assign w_memwb_fwd = 1'b0;

    logic w_hit_rs, w_hit_rt;
    assign w_hit_rs = f_hit(r_ex.valid & r_ex.wb_en, r_ex.rd_addr, id_rs_addr) |
                      f_hit(exmem_wb_en, exmem_rd_addr, id_rs_addr) |
                      f_hit(memwb_wb_en, memwb_rd_addr, id_rs_addr);
    assign w_hit_rt = f_hit(r_ex.valid & r_ex.wb_en, r_ex.rd_addr, id_rt_addr) |
                      f_hit(exmem_wb_en, exmem_rd_addr, id_rt_addr) |
                      f_hit(memwb_wb_en, memwb_rd_addr, id_rt_addr);
    assign hazard_stall = id_valid & (w_hit_rs | (!id_use_imm & w_hit_rt));
`endif

    // Load path: bypass the decode-slot operands.
    operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_ld_rs (
        .i_src_addr(id_rs_addr), .i_dflt_data(id_rs_data),
        .i_exmem_wb_en(w_exmem_fwd), .i_exmem_rd_addr(exmem_rd_addr), .i_exmem_result(exmem_result),
        .i_memwb_wb_en(w_memwb_fwd), .i_memwb_rd_addr(memwb_rd_addr), .i_memwb_result(memwb_result),
        .o_data(w_ld_rs)
    );
    operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_ld_rt (
        .i_src_addr(id_rt_addr), .i_dflt_data(id_rt_data),
        .i_exmem_wb_en(w_exmem_fwd), .i_exmem_rd_addr(exmem_rd_addr), .i_exmem_result(exmem_result),
        .i_memwb_wb_en(w_memwb_fwd), .i_memwb_rd_addr(memwb_rd_addr), .i_memwb_result(memwb_result),
        .o_data(w_ld_rt)
    );

    // Refresh path: default is the held operand, so no match means keep it.
    operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_rf_rs (
        .i_src_addr(r_ex.rs_addr), .i_dflt_data(r_ex.rs),
        .i_exmem_wb_en(w_exmem_fwd), .i_exmem_rd_addr(exmem_rd_addr), .i_exmem_result(exmem_result),
        .i_memwb_wb_en(w_memwb_fwd), .i_memwb_rd_addr(memwb_rd_addr), .i_memwb_result(memwb_result),
        .o_data(w_rf_rs)
    );
    operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_rf_rt (
        .i_src_addr(r_ex.rt_addr), .i_dflt_data(r_ex.rt),
        .i_exmem_wb_en(w_exmem_fwd), .i_exmem_rd_addr(exmem_rd_addr), .i_exmem_result(exmem_result),
        .i_memwb_wb_en(w_memwb_fwd), .i_memwb_rd_addr(memwb_rd_addr), .i_memwb_result(memwb_result),
        .o_data(w_rf_rt)
    );

    always_comb begin
        w_bubble        = '0;
        w_bubble.alu_op = ALU_OP_NOP;
    end

    always_comb begin
        w_load          = '0;
        w_load.valid    = id_valid;
        w_load.alu_op   = id_alu_op;
        w_load.rs_addr  = id_rs_addr;
        w_load.rt_addr  = id_rt_addr;
        w_load.rd_addr  = id_rd_addr;
        // Side effects only exist for a real instruction.
        w_load.wb_en    = id_valid & id_wb_en;
        w_load.mem_read = id_valid & id_mem_read;
        w_load.use_imm  = id_use_imm;
        w_load.rs       = w_ld_rs;
        w_load.rt       = id_use_imm ? id_imm : w_ld_rt;
    end

    always_comb begin
        w_hold = r_ex;
        if (r_ex.valid) begin
            w_hold.rs = w_rf_rs;
            if (!r_ex.use_imm)
                w_hold.rt = w_rf_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)            r_ex <= w_bubble;
        else if (flush)        r_ex <= w_bubble;
        else if (stall)        r_ex <= w_hold;
        else if (hazard_stall) r_ex <= w_bubble;
        else                   r_ex <= w_load;
    end

    assign ex_valid    = r_ex.valid;
    assign ex_alu_en   = r_ex.valid;
    assign ex_alu_op   = r_ex.alu_op;
    assign ex_rs       = r_ex.rs;
    assign ex_rt       = r_ex.rt;
    assign ex_rs_addr  = r_ex.rs_addr;
    assign ex_rt_addr  = r_ex.rt_addr;
    assign ex_rd_addr  = r_ex.rd_addr;
    assign ex_wb_en    = r_ex.wb_en;
    assign ex_mem_read = r_ex.mem_read;
    assign ex_use_imm  = r_ex.use_imm;

endmodule
